// File: rtl/int_seq_pkg.sv
// rtl/int_seq_pkg.sv - shared types and constants for the interrupt sequencer
package int_seq_pkg;

    typedef enum logic [2:0] {
        RST_HOLD,
        IDLE,
        PUSH_PCH,
        PUSH_PCL,
        PUSH_P,
        VEC_SEL,
        FETCH_LO,
        FETCH_HI
    } state_e;

    typedef enum logic [1:0] {
        KIND_NONE,
        KIND_RESET,
        KIND_BRK,
        KIND_INT
    } kind_e;

    localparam logic [1:0] DB_NONE = 2'd0;
    localparam logic [1:0] DB_PCH  = 2'd1;
    localparam logic [1:0] DB_PCL  = 2'd2;
    localparam logic [1:0] DB_P    = 2'd3;

    localparam logic [7:0] NMI_VEC_DEF = 8'hFA;
    localparam logic [7:0] RST_VEC_DEF = 8'hFC;
    localparam logic [7:0] IRQ_VEC_DEF = 8'hFE;

endpackage

// File: rtl/nmi_edge_det.sv
// rtl/nmi_edge_det.sv - NMI falling-edge detector with pending latch
module nmi_edge_det (
    input  logic clk_i,
    input  logic reset_i,
    input  logic nmi_n_i,
    input  logic clr_i,
    output logic pend_o
);

    logic nmi_q;
    logic pend_q;
    logic pend_d;

    // A fresh edge wins over a same-cycle clear so it stays pending.
    always_comb begin
        pend_d = pend_q;
        if (clr_i) begin
            pend_d = 1'b0;
        end
        if (nmi_q && !nmi_n_i) begin
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            nmi_q  <= 1'b1;
            pend_q <= 1'b0;
        end else begin
            nmi_q  <= nmi_n_i;
            pend_q <= pend_d;
        end
    end

    assign pend_o = pend_q;

endmodule

// File: rtl/int_seq.sv
// rtl/int_seq.sv - reset/NMI/IRQ/BRK entry sequencer: stack pushes, vector select, vector fetch
module int_seq
    import int_seq_pkg::*;
#(
    parameter logic [7:0] NMI_VEC = NMI_VEC_DEF,
    parameter logic [7:0] RST_VEC = RST_VEC_DEF,
    parameter logic [7:0] IRQ_VEC = IRQ_VEC_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rdy,
    input  logic       inst_done,
    input  logic       brk,
    input  logic       nmi_n,
    input  logic       irq_n,
    input  logic       iflag,
    output logic       setreset,
    output logic       setnmi,
    output logic       setirq,
    output logic [1:0] db_sel,
    output logic       mem_wr,
    output logic       sp_dec,
    output logic       adl_oe,
    output logic       pcl_inc,
    output logic       vec_lo_ld,
    output logic       vec_hi_ld,
    output logic       b_flag,
    output logic       set_i,
    output logic       busy,
    output logic       seq_done
);

    state_e state_q, state_d;
    kind_e  kind_q, kind_d;
    logic   nmi_pend;
    logic   nmi_clr;
    logic   push;

    nmi_edge_det u_nmi_edge_det (
        .clk_i   (clk),
        .reset_i (reset),
        .nmi_n_i (nmi_n),
        .clr_i   (nmi_clr),
        .pend_o  (nmi_pend)
    );

    always_comb begin
        state_d   = state_q;
        kind_d    = kind_q;
        nmi_clr   = 1'b0;
        push      = 1'b0;
        setreset  = 1'b0;
        setnmi    = 1'b0;
        setirq    = 1'b0;
        db_sel    = DB_NONE;
        mem_wr    = 1'b0;
        sp_dec    = 1'b0;
        adl_oe    = 1'b0;
        pcl_inc   = 1'b0;
        vec_lo_ld = 1'b0;
        vec_hi_ld = 1'b0;
        b_flag    = 1'b0;
        set_i     = 1'b0;
        seq_done  = 1'b0;
        busy      = (state_q != IDLE);

        case (state_q)
            RST_HOLD: begin
                if (rdy) begin
                    state_d = PUSH_PCH;
                    kind_d  = KIND_RESET;
                end
            end
            IDLE: begin
                if (rdy && inst_done && (nmi_pend || brk || (!irq_n && !iflag))) begin
                    state_d = PUSH_PCH;
                    kind_d  = brk ? KIND_BRK : KIND_INT;
                end
            end
            PUSH_PCH: begin
                db_sel = DB_PCH;
                push   = 1'b1;
                if (rdy) state_d = PUSH_PCL;
            end
            PUSH_PCL: begin
                db_sel = DB_PCL;
                push   = 1'b1;
                if (rdy) state_d = PUSH_P;
            end
            PUSH_P: begin
                db_sel = DB_P;
                push   = 1'b1;
                b_flag = (kind_q == KIND_BRK);
                if (rdy) state_d = VEC_SEL;
            end
            // Late NMI hijacks a BRK/IRQ entry here; reset always wins.
            VEC_SEL: begin
                if (rdy) begin
                    set_i   = 1'b1;
                    state_d = FETCH_LO;
                    if (kind_q == KIND_RESET) begin
                        setreset = 1'b1;
                    end else if (nmi_pend) begin
                        setnmi  = 1'b1;
                        nmi_clr = 1'b1;
                    end else begin
                        setirq = 1'b1;
                    end
                end
            end
            FETCH_LO: begin
                adl_oe = 1'b1;
                if (rdy) begin
                    vec_lo_ld = 1'b1;
                    pcl_inc   = 1'b1;
                    state_d   = FETCH_HI;
                end
            end
            FETCH_HI: begin
                adl_oe = 1'b1;
                if (rdy) begin
                    vec_hi_ld = 1'b1;
                    seq_done  = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = RST_HOLD;
        endcase

        // Reset entry performs dummy pushes: SP still moves, memory is untouched.
        if (push && rdy) begin
            sp_dec = 1'b1;
            mem_wr = (kind_q != KIND_RESET);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RST_HOLD;
            kind_q  <= KIND_NONE;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
        end
    end

    vec_distinct_a: assert property (@(posedge clk)
        (NMI_VEC != RST_VEC) && (NMI_VEC != IRQ_VEC) && (RST_VEC != IRQ_VEC));

endmodule

// File: tb/tb_int_seq.sv
// tb/tb_int_seq.sv - self-checking bench for int_seq against a sequence-position reference model
module tb_int_seq;

    logic       clk = 1'b0;
    logic       reset, rdy, inst_done, brk, nmi_n, irq_n, iflag;
    logic       setreset, setnmi, setirq, mem_wr, sp_dec, adl_oe, pcl_inc;
    logic       vec_lo_ld, vec_hi_ld, b_flag, set_i, busy, seq_done;
    logic [1:0] db_sel;
    logic [14:0] dut_vec;

    int checks   = 0;
    int failures = 0;

    // Reference model: position within the 6-cycle entry sequence
    // (-1 = held in reset, 0 = idle, 1..6 = sequence cycles).
    localparam int K_NONE = 0, K_RST = 1, K_BRK = 2, K_INT = 3;
    int   m_pos  = -1;
    int   m_kind = K_NONE;
    logic m_pend = 1'b0;
    logic m_nmi_prev = 1'b1;

    int_seq dut (
        .clk       (clk),
        .reset     (reset),
        .rdy       (rdy),
        .inst_done (inst_done),
        .brk       (brk),
        .nmi_n     (nmi_n),
        .irq_n     (irq_n),
        .iflag     (iflag),
        .setreset  (setreset),
        .setnmi    (setnmi),
        .setirq    (setirq),
        .db_sel    (db_sel),
        .mem_wr    (mem_wr),
        .sp_dec    (sp_dec),
        .adl_oe    (adl_oe),
        .pcl_inc   (pcl_inc),
        .vec_lo_ld (vec_lo_ld),
        .vec_hi_ld (vec_hi_ld),
        .b_flag    (b_flag),
        .set_i     (set_i),
        .busy      (busy),
        .seq_done  (seq_done)
    );

    always #5 clk = ~clk;

    assign dut_vec = {setreset, setnmi, setirq, db_sel, mem_wr, sp_dec, adl_oe,
                      pcl_inc, vec_lo_ld, vec_hi_ld, b_flag, set_i, busy, seq_done};

    function automatic logic [14:0] exp_out();
        logic sr, sn, sq, mw, sd, adl, pinc, vlo, vhi, bf, seti, bsy, dn;
        logic [1:0] db;
        {sr, sn, sq, mw, sd, adl, pinc, vlo, vhi, bf, seti, dn} = '0;
        db  = 2'd0;
        bsy = (m_pos != 0);
        if (m_pos >= 1 && m_pos <= 3) begin
            db = m_pos[1:0];
            sd = rdy;
            mw = rdy && (m_kind != K_RST);
        end
        bf = (m_pos == 3) && (m_kind == K_BRK);
        if (m_pos == 4 && rdy) begin
            seti = 1'b1;
            if (m_kind == K_RST) sr = 1'b1;
            else if (m_pend)     sn = 1'b1;
            else                 sq = 1'b1;
        end
        adl = (m_pos == 5) || (m_pos == 6);
        if (m_pos == 5 && rdy) begin vlo = 1'b1; pinc = 1'b1; end
        if (m_pos == 6 && rdy) begin vhi = 1'b1; dn = 1'b1; end
        return {sr, sn, sq, db, mw, sd, adl, pinc, vlo, vhi, bf, seti, bsy, dn};
    endfunction

    task automatic drive(input logic rs, input logic rd, input logic id, input logic bk,
                         input logic nn, input logic iq, input logic ifl);
        reset = rs; rdy = rd; inst_done = id; brk = bk; nmi_n = nn; irq_n = iq; iflag = ifl;
        #1;
    endtask

    task automatic clk_step();
        logic edge_c, clr_c, pend_old;
        pend_old = m_pend;
        edge_c   = m_nmi_prev && !nmi_n;
        clr_c    = rdy && (m_pos == 4) && (m_kind != K_RST) && m_pend;
        if (reset) begin
            m_pend = 1'b0; m_nmi_prev = 1'b1; m_pos = -1; m_kind = K_NONE;
        end else begin
            m_nmi_prev = nmi_n;
            if (edge_c)     m_pend = 1'b1;
            else if (clr_c) m_pend = 1'b0;
            if (rdy) begin
                if (m_pos == -1) begin
                    m_pos = 1; m_kind = K_RST;
                end else if (m_pos == 0) begin
                    if (inst_done && (pend_old || brk || (!irq_n && !iflag))) begin
                        m_pos = 1; m_kind = brk ? K_BRK : K_INT;
                    end
                end else if (m_pos == 6) begin
                    m_pos = 0;
                end else begin
                    m_pos = m_pos + 1;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int mw_seen = 0;
        drive(1, 1, 0, 0, 1, 1, 0); clk_step(); clk_step();
        drive(1, 1, 1, 1, 1, 0, 0);
        checks++;
        if (dut_vec !== 15'h0002) begin failures++; $display("FAIL rst_hold_outputs got=%h exp=%h", dut_vec, 15'h0002); end
        for (int k = 0; k <= 8; k++) begin
            drive(0, 1, 0, 0, 1, 1, 0);
            checks++;
            if (dut_vec !== exp_out()) begin failures++; $display("FAIL rst_trace k=%0d got=%h exp=%h", k, dut_vec, exp_out()); end
            if (mem_wr) mw_seen++;
            if (k == 4) begin checks++; if (setreset !== 1'b1) begin failures++; $display("FAIL rst_setreset got=%b exp=1", setreset); end end
            if (k == 6) begin checks++; if (seq_done !== 1'b1) begin failures++; $display("FAIL rst_seq_done got=%b exp=1", seq_done); end end
            if (k == 7) begin checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy_idle got=%b exp=0", busy); end end
            clk_step();
        end
        checks++;
        if (mw_seen != 0) begin failures++; $display("FAIL rst_no_mem_wr got=%0d exp=0", mw_seen); end
    endtask

    task automatic test_irq();
        int mw_cnt = 0;
        for (int k = 0; k <= 8; k++) begin
            drive(0, 1, k == 0, 0, 1, (k < 2) ? 1'b0 : 1'b1, 0);
            checks++;
            if (dut_vec !== exp_out()) begin failures++; $display("FAIL irq_trace k=%0d got=%h exp=%h", k, dut_vec, exp_out()); end
            if (mem_wr) mw_cnt++;
            if (k >= 1 && k <= 3) begin
                checks++;
                if (db_sel !== k[1:0] || b_flag !== 1'b0) begin failures++; $display("FAIL irq_push k=%0d got=%0d/%b exp=%0d/0", k, db_sel, b_flag, k); end
            end
            if (k == 4) begin checks++; if (setirq !== 1'b1) begin failures++; $display("FAIL irq_setirq got=%b exp=1", setirq); end end
            clk_step();
        end
        checks++;
        if (mw_cnt != 3) begin failures++; $display("FAIL irq_mem_wr_count got=%0d exp=3", mw_cnt); end
    endtask

    task automatic test_masked_brk();
        for (int k = 0; k <= 2; k++) begin
            drive(0, 1, k == 0, 0, 1, 0, 1);
            checks++;
            if (busy !== 1'b0 || dut_vec !== exp_out()) begin failures++; $display("FAIL masked_idle k=%0d got=%h exp=%h", k, dut_vec, exp_out()); end
            clk_step();
        end
        for (int k = 0; k <= 7; k++) begin
            drive(0, 1, k == 0, k == 0, 1, 0, 1);
            checks++;
            if (dut_vec !== exp_out()) begin failures++; $display("FAIL brk_trace k=%0d got=%h exp=%h", k, dut_vec, exp_out()); end
            if (k == 3) begin checks++; if (b_flag !== 1'b1) begin failures++; $display("FAIL brk_b_flag got=%b exp=1", b_flag); end end
            if (k == 4) begin checks++; if (setirq !== 1'b1) begin failures++; $display("FAIL brk_setirq got=%b exp=1", setirq); end end
            clk_step();
        end
    endtask

    task automatic test_nmi_hijack();
        for (int k = 0; k <= 9; k++) begin
            drive(0, 1, (k == 0) || (k == 8), k == 0, (k < 2) ? 1'b1 : 1'b0, 1, 0);
            checks++;
            if (dut_vec !== exp_out()) begin failures++; $display("FAIL hijack_trace k=%0d got=%h exp=%h", k, dut_vec, exp_out()); end
            if (k == 3) begin checks++; if (b_flag !== 1'b1) begin failures++; $display("FAIL hijack_b_flag got=%b exp=1", b_flag); end end
            if (k == 4) begin checks++; if (setnmi !== 1'b1 || setirq !== 1'b0) begin failures++; $display("FAIL hijack_vec got=%b%b exp=10", setnmi, setirq); end end
            if (k == 9) begin checks++; if (busy !== 1'b0) begin failures++; $display("FAIL hijack_pend_cleared got=%b exp=0", busy); end end
            clk_step();
        end
        drive(0, 1, 0, 0, 1, 1, 0); clk_step();
    endtask

    task automatic test_rdy_stall();
        for (int k = 0; k <= 9; k++) begin
            drive(0, (k == 2 || k == 3) ? 1'b0 : 1'b1, k == 0, 0, 1, 0, 0);
            checks++;
            if (dut_vec !== exp_out()) begin failures++; $display("FAIL stall_trace k=%0d got=%h exp=%h", k, dut_vec, exp_out()); end
            if (k == 2 || k == 3) begin
                checks++;
                if (db_sel !== 2'd2 || mem_wr !== 1'b0 || sp_dec !== 1'b0 || busy !== 1'b1) begin
                    failures++; $display("FAIL stall_hold k=%0d got=%0d%b%b%b exp=2001", k, db_sel, mem_wr, sp_dec, busy);
                end
            end
            if (k == 8) begin checks++; if (seq_done !== 1'b1) begin failures++; $display("FAIL stall_seq_done got=%b exp=1", seq_done); end end
            clk_step();
        end
    endtask

    task automatic test_reset_mid();
        int vhi_early = 0;
        for (int k = 0; k <= 13; k++) begin
            drive(k == 5, 1, k == 0, 0, 1, (k == 0) ? 1'b0 : 1'b1, 0);
            checks++;
            if (dut_vec !== exp_out()) begin failures++; $display("FAIL rstmid_trace k=%0d got=%h exp=%h", k, dut_vec, exp_out()); end
            if (k < 12 && vec_hi_ld) vhi_early++;
            if (k == 6) begin checks++; if (dut_vec !== 15'h0002) begin failures++; $display("FAIL rstmid_hold got=%h exp=%h", dut_vec, 15'h0002); end end
            if (k == 10) begin checks++; if (setreset !== 1'b1) begin failures++; $display("FAIL rstmid_setreset got=%b exp=1", setreset); end end
            clk_step();
        end
        checks++;
        if (vhi_early != 0) begin failures++; $display("FAIL rstmid_no_vec_hi got=%0d exp=0", vhi_early); end
    endtask

    task automatic test_nmi_repend();
        for (int k = 0; k <= 15; k++) begin
            drive(0, 1, (k == 1) || (k == 8), 0, (k == 0 || k >= 5) ? 1'b0 : 1'b1, 1, 1);
            checks++;
            if (dut_vec !== exp_out()) begin failures++; $display("FAIL repend_trace k=%0d got=%h exp=%h", k, dut_vec, exp_out()); end
            if (k == 5 || k == 12) begin checks++; if (setnmi !== 1'b1) begin failures++; $display("FAIL repend_setnmi k=%0d got=%b exp=1", k, setnmi); end end
            if (k == 9) begin checks++; if (busy !== 1'b1) begin failures++; $display("FAIL repend_restart got=%b exp=1", busy); end end
            clk_step();
        end
        drive(0, 1, 0, 0, 1, 1, 0); clk_step();
    endtask

    task automatic test_random();
        logic nn = 1'b1;
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 5) == 0) nn = ~nn;
            drive($urandom_range(0, 63) == 0, $urandom_range(0, 4) != 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 3) == 0, nn, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            checks++;
            if (dut_vec !== exp_out()) begin failures++; $display("FAIL random_trace k=%0d got=%h exp=%h", k, dut_vec, exp_out()); end
            clk_step();
        end
    endtask

    initial begin
        test_reset();
        test_irq();
        test_masked_brk();
        test_nmi_hijack();
        test_rdy_stall();
        test_reset_mid();
        test_nmi_repend();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
